gen_scheduler: RTL and testbench

Central sequencer for the Game of Life core: decides when the next-generation engine runs and when a stored config is loaded, and owns the A/B field ping-pong selection. It replaces the separate NFI/FCL controllers. It handshakes with the iterator (NFI) and the config loader (FCL), paces generations by VGA frames, and swaps the displayed field only on a frame boundary so the picture never tears.

---
 rtl/gen_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_gen_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_scheduler.sv
// Generation scheduler for the Game of Life core.
// Sequences config loads (FCL) and generation runs (NFI), paces generations
// by VGA frames, and flips the A/B read field only on a frame boundary so
// the displayed picture never tears.
module gen_scheduler #(
    parameter int GEN_PERIOD_FRAMES = 10,
    parameter int GEN_CNT_W         = 16,
    parameter int ACK_TIMEOUT       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cmd_toggle_pause,
    input  logic                 i_cmd_step,
    input  logic                 i_cmd_load_cfg_1,
    input  logic                 i_cmd_load_cfg_2,
    input  logic                 i_frame_start,
    input  logic                 i_nfi_busy,
    input  logic                 i_fcl_busy,
    output logic                 o_nfi_go,
    output logic                 o_fcl_go,
    output logic [1:0]           o_fcl_cfg,
    output logic                 o_read_field,
    output logic                 o_running,
    output logic [GEN_CNT_W-1:0] o_gen_count,
    output logic                 o_err
);

    localparam int FC_W = (GEN_PERIOD_FRAMES > 1) ? $clog2(GEN_PERIOD_FRAMES) : 1;
    localparam int TO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_GO   = 3'd1,
        S_LOAD_ACK  = 3'd2,
        S_LOAD_DONE = 3'd3,
        S_SIM_GO    = 3'd4,
        S_SIM_ACK   = 3'd5,
        S_SIM_DONE  = 3'd6,
        S_SWAP_WAIT = 3'd7
    } state_t;

    state_t                 state_r, next_state_s;
    logic                   timeout_s;
    logic [FC_W-1:0]        frame_cnt_r, frame_cnt_s;
    logic [TO_W-1:0]        to_cnt_r, to_cnt_s;
    logic [1:0]             pend_r, pend_s;
    logic                   frame_last_s;
    logic                   nfi_go_s, fcl_go_s, read_field_s, running_s, err_s;
    logic [1:0]             fcl_cfg_s;
    logic [GEN_CNT_W-1:0]   gen_count_s;

    assign frame_last_s = (frame_cnt_r == FC_W'(GEN_PERIOD_FRAMES - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode, including the handshake timeout detection.
    always_comb begin
        next_state_s = state_r;
        timeout_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                // Never launch a go while a peer still reports busy.
                if (i_nfi_busy || i_fcl_busy) begin
                    next_state_s = S_IDLE;
                end else if (pend_r != 2'd0) begin
                    next_state_s = S_LOAD_GO;
                end else if (o_running && i_frame_start && frame_last_s) begin
                    next_state_s = S_SIM_GO;
                end else if (!o_running && i_cmd_step) begin
                    next_state_s = S_SIM_GO;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_LOAD_GO: next_state_s = S_LOAD_ACK;
            S_LOAD_ACK: begin
                if (i_fcl_busy) begin
                    next_state_s = S_LOAD_DONE;
                end else if (to_cnt_r == TO_W'(ACK_TIMEOUT)) begin
                    next_state_s = S_IDLE;
                    timeout_s    = 1'b1;
                end else begin
                    next_state_s = S_LOAD_ACK;
                end
            end
            S_LOAD_DONE: next_state_s = i_fcl_busy ? S_LOAD_DONE : S_IDLE;
            S_SIM_GO:    next_state_s = S_SIM_ACK;
            S_SIM_ACK: begin
                if (i_nfi_busy) begin
                    next_state_s = S_SIM_DONE;
                end else if (to_cnt_r == TO_W'(ACK_TIMEOUT)) begin
                    next_state_s = S_IDLE;
                    timeout_s    = 1'b1;
                end else begin
                    next_state_s = S_SIM_ACK;
                end
            end
            // A frame_start in the cycle busy falls is deliberately not used.
            S_SIM_DONE:  next_state_s = i_nfi_busy ? S_SIM_DONE : S_SWAP_WAIT;
            S_SWAP_WAIT: next_state_s = i_frame_start ? S_IDLE : S_SWAP_WAIT;
            default:     next_state_s = S_IDLE;
        endcase
    end

    // Output and datapath next values; every output is registered below.
    always_comb begin
        nfi_go_s     = (next_state_s == S_SIM_GO);
        fcl_go_s     = (next_state_s == S_LOAD_GO);
        running_s    = o_running ^ i_cmd_toggle_pause;
        err_s        = o_err | timeout_s;

        if (i_cmd_load_cfg_2) begin
            pend_s = 2'd2;
        end else if (i_cmd_load_cfg_1) begin
            pend_s = 2'd1;
        end else if (next_state_s == S_LOAD_GO) begin
            pend_s = 2'd0;
        end else begin
            pend_s = pend_r;
        end

        if (next_state_s == S_LOAD_GO) begin
            fcl_cfg_s = pend_r;
        end else if (next_state_s == S_IDLE && state_r != S_IDLE) begin
            fcl_cfg_s = 2'd0;
        end else begin
            fcl_cfg_s = o_fcl_cfg;
        end

        if ((state_r == S_LOAD_ACK || state_r == S_SIM_ACK) && next_state_s == state_r) begin
            to_cnt_s = to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_s = '0;
        end

        if (state_r == S_LOAD_DONE && next_state_s == S_IDLE) begin
            gen_count_s  = '0;
            read_field_s = o_read_field;
        end else if (state_r == S_SWAP_WAIT && next_state_s == S_IDLE) begin
            gen_count_s  = o_gen_count + GEN_CNT_W'(1);
            read_field_s = ~o_read_field;
        end else begin
            gen_count_s  = o_gen_count;
            read_field_s = o_read_field;
        end

        if (state_r == S_LOAD_DONE && next_state_s == S_IDLE) begin
            frame_cnt_s = '0;
        end else if (state_r == S_IDLE && next_state_s == S_SIM_GO && o_running) begin
            frame_cnt_s = '0;
        end else if (state_r == S_IDLE && next_state_s == S_IDLE && o_running
                     && i_frame_start && !frame_last_s) begin
            frame_cnt_s = frame_cnt_r + FC_W'(1);
        end else begin
            frame_cnt_s = frame_cnt_r;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_nfi_go     <= 1'b0;
            o_fcl_go     <= 1'b0;
            o_fcl_cfg    <= 2'd0;
            o_read_field <= 1'b0;
            o_running    <= 1'b0;
            o_gen_count  <= '0;
            o_err        <= 1'b0;
            frame_cnt_r  <= '0;
            to_cnt_r     <= '0;
            pend_r       <= 2'd0;
        end else begin
            o_nfi_go     <= nfi_go_s;
            o_fcl_go     <= fcl_go_s;
            o_fcl_cfg    <= fcl_cfg_s;
            o_read_field <= read_field_s;
            o_running    <= running_s;
            o_gen_count  <= gen_count_s;
            o_err        <= err_s;
            frame_cnt_r  <= frame_cnt_s;
            to_cnt_r     <= to_cnt_s;
            pend_r       <= pend_s;
        end
    end

endmodule

// File: tb/tb_gen_scheduler.sv
// Scoreboard bench for gen_scheduler: expected go pulses and field swaps are
// queued as stimulus is driven and compared when the DUT produces them.
module tb_gen_scheduler;

    localparam int GEN_CNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 i_cmd_toggle_pause = 1'b0;
    logic                 i_cmd_step = 1'b0;
    logic                 i_cmd_load_cfg_1 = 1'b0;
    logic                 i_cmd_load_cfg_2 = 1'b0;
    logic                 i_frame_start = 1'b0;
    logic                 i_nfi_busy = 1'b0;
    logic                 i_fcl_busy = 1'b0;
    logic                 o_nfi_go, o_fcl_go, o_read_field, o_running, o_err;
    logic [1:0]           o_fcl_cfg;
    logic [GEN_CNT_W-1:0] o_gen_count;

    gen_scheduler #(.GEN_PERIOD_FRAMES(3), .GEN_CNT_W(GEN_CNT_W), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_toggle_pause(i_cmd_toggle_pause), .i_cmd_step(i_cmd_step),
        .i_cmd_load_cfg_1(i_cmd_load_cfg_1), .i_cmd_load_cfg_2(i_cmd_load_cfg_2),
        .i_frame_start(i_frame_start), .i_nfi_busy(i_nfi_busy), .i_fcl_busy(i_fcl_busy),
        .o_nfi_go(o_nfi_go), .o_fcl_go(o_fcl_go), .o_fcl_cfg(o_fcl_cfg),
        .o_read_field(o_read_field), .o_running(o_running),
        .o_gen_count(o_gen_count), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected events.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = nfi go, 1 = fcl go (val = cfg), 2 = field/count change (val = gen*2+rf)
    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;
    ev_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int exp_gen = 0;
    int exp_rf = 0;
    int prev_rf = 0;
    int prev_gc = 0;
    bit nfi_never = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int val);
        ev_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected_kind", kind, -1);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_val", val, e.val);
            if (e.cyc >= 0) chk("sb_cyc", cyc, e.cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic frame_pulse();
        i_frame_start = 1'b1;
        tick(1);
        i_frame_start = 1'b0;
    endtask

    task automatic step_pulse();
        i_cmd_step = 1'b1;
        tick(1);
        i_cmd_step = 1'b0;
    endtask

    task automatic toggle_pulse();
        i_cmd_toggle_pause = 1'b1;
        tick(1);
        i_cmd_toggle_pause = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_nfi_go"}, int'(o_nfi_go), 0);
        chk({tag, "_fcl_go"}, int'(o_fcl_go), 0);
        chk({tag, "_fcl_cfg"}, int'(o_fcl_cfg), 0);
        chk({tag, "_read_field"}, int'(o_read_field), 0);
        chk({tag, "_running"}, int'(o_running), 0);
        chk({tag, "_gen_count"}, int'(o_gen_count), 0);
        chk({tag, "_err"}, int'(o_err), 0);
    endtask

    // NFI model: busy for 20 cycles after each go, unless told never to answer.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && o_nfi_go && !nfi_never) begin
                i_nfi_busy = 1'b1;
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk);
                    #1;
                    if (!rst_n) break;
                end
                i_nfi_busy = 1'b0;
            end
        end
    end

    // FCL model: busy for 5 cycles after each go.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && o_fcl_go) begin
                i_fcl_busy = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk);
                    #1;
                    if (!rst_n) break;
                end
                i_fcl_busy = 1'b0;
            end
        end
    end

    // Monitor: every go pulse and every read_field/gen_count change pops the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_rf = 0;
                prev_gc = 0;
                continue;
            end
            if (o_nfi_go && o_fcl_go) chk("go_exclusive", 1, 0);
            if (o_nfi_go) check_ev(0, 0);
            if (o_fcl_go) check_ev(1, int'(o_fcl_cfg));
            if (int'(o_read_field) != prev_rf || int'(o_gen_count) != prev_gc)
                check_ev(2, int'(o_gen_count) * 2 + int'(o_read_field));
            prev_rf = int'(o_read_field);
            prev_gc = int'(o_gen_count);
        end
    end

    initial begin
        int n;
        int f;

        // Reset values.
        tick(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Load cfg_1: go two cycles after the pulse, cfg held, then cleared.
        n = cyc;
        push_ev(1, 1, n + 2);
        i_cmd_load_cfg_1 = 1'b1;
        tick(1);
        i_cmd_load_cfg_1 = 1'b0;
        tick(1);
        chk("load1_cfg_held", int'(o_fcl_cfg), 1);
        tick(15);
        chk("load1_cfg_cleared", int'(o_fcl_cfg), 0);
        chk("load1_gen_count", int'(o_gen_count), 0);
        chk("load1_read_field", int'(o_read_field), 0);

        // Free-running: go on every 3rd idle frame, swap on the following frame.
        toggle_pulse();
        chk("run_on", int'(o_running), 1);
        for (int k = 1; k <= 12; k++) begin
            tick(29);
            f = cyc;
            if (k % 4 == 3) begin
                push_ev(0, 0, f + 1);
            end else if (k % 4 == 0) begin
                exp_gen++;
                exp_rf ^= 1;
                push_ev(2, exp_gen * 2 + exp_rf, f + 1);
            end
            frame_pulse();
        end
        chk("run_gen_count", int'(o_gen_count), 3);
        tick(2);
        toggle_pulse();
        chk("run_off", int'(o_running), 0);

        // Paused step; a frame in the busy-fall cycle must not swap.
        tick(2);
        n = cyc;
        push_ev(0, 0, n + 1);
        step_pulse();
        wait_until(n + 21);
        frame_pulse();
        wait_until(n + 30);
        f = cyc;
        exp_gen = 4;
        exp_rf = 0;
        push_ev(2, exp_gen * 2 + exp_rf, f + 1);
        frame_pulse();
        tick(3);

        // Step while running is ignored.
        toggle_pulse();
        chk("run_on2", int'(o_running), 1);
        tick(2);
        step_pulse();
        tick(30);
        chk("run_step_ignored", sb.size(), 0);
        toggle_pulse();
        chk("run_off2", int'(o_running), 0);

        // Toggle and step together while paused: step uses pre-toggle state.
        tick(2);
        n = cyc;
        push_ev(0, 0, n + 1);
        i_cmd_toggle_pause = 1'b1;
        i_cmd_step = 1'b1;
        tick(1);
        i_cmd_toggle_pause = 1'b0;
        i_cmd_step = 1'b0;
        chk("toggle_step_running", int'(o_running), 1);
        wait_until(n + 30);
        f = cyc;
        exp_gen = 5;
        exp_rf = 1;
        push_ev(2, exp_gen * 2 + exp_rf, f + 1);
        frame_pulse();
        tick(2);
        toggle_pulse();
        chk("run_off3", int'(o_running), 0);

        // Loads during SIM_DONE stay pending; cfg_2 overwrites cfg_1, served after swap.
        tick(2);
        n = cyc;
        push_ev(0, 0, n + 1);
        step_pulse();
        wait_until(n + 6);
        i_cmd_load_cfg_1 = 1'b1;
        tick(1);
        i_cmd_load_cfg_1 = 1'b0;
        i_cmd_load_cfg_2 = 1'b1;
        tick(1);
        i_cmd_load_cfg_2 = 1'b0;
        wait_until(n + 30);
        f = cyc;
        exp_gen = 6;
        exp_rf = 0;
        push_ev(2, exp_gen * 2 + exp_rf, f + 1);
        push_ev(1, 2, f + 2);
        push_ev(2, 0, -1);
        frame_pulse();
        tick(1);
        chk("pend_cfg2", int'(o_fcl_cfg), 2);
        tick(15);
        chk("pend_cfg_cleared", int'(o_fcl_cfg), 0);
        chk("pend_gen_cleared", int'(o_gen_count), 0);
        exp_gen = 0;

        // NFI never answers: error after the timeout, no swap.
        tick(2);
        nfi_never = 1'b1;
        n = cyc;
        push_ev(0, 0, n + 1);
        step_pulse();
        wait_until(n + 6);
        chk("timeout_err_early", int'(o_err), 0);
        tick(1);
        chk("timeout_err", int'(o_err), 1);
        chk("timeout_read_field", int'(o_read_field), 0);
        chk("timeout_gen_count", int'(o_gen_count), 0);
        nfi_never = 1'b0;
        tick(3);
        n = cyc;
        push_ev(0, 0, n + 1);
        step_pulse();
        wait_until(n + 30);
        f = cyc;
        exp_gen = 1;
        exp_rf = 1;
        push_ev(2, exp_gen * 2 + exp_rf, f + 1);
        frame_pulse();
        tick(2);
        chk("err_sticky", int'(o_err), 1);

        // Asynchronous reset during SIM_DONE.
        tick(2);
        n = cyc;
        push_ev(0, 0, n + 1);
        step_pulse();
        wait_until(n + 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick(3);
        rst_n = 1'b1;
        exp_gen = 0;
        exp_rf = 0;
        tick(2);
        n = cyc;
        push_ev(0, 0, n + 1);
        step_pulse();
        wait_until(n + 30);
        f = cyc;
        exp_gen = 1;
        exp_rf = 1;
        push_ev(2, exp_gen * 2 + exp_rf, f + 1);
        frame_pulse();
        tick(5);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
